// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Each access is a fixed IDLE -> ACCESS -> RESP sequence for one requester at a time.
module dmem_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_we,
    input  logic [WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    input  logic [2:0]       req0_ctrl,
    output logic             req0_rvalid,
    output logic [WIDTH-1:0] req0_rdata,
    output logic             req0_err,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_we,
    input  logic [WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    input  logic [2:0]       req1_ctrl,
    output logic             req1_rvalid,
    output logic [WIDTH-1:0] req1_rdata,
    output logic             req1_err,

    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [2:0]       mem_ctrl,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        MEM_BYTE, MEM_HALFWORD, MEM_WORD, MEM_DWORD,
        MEM_BYTE_U, MEM_HALFWORD_U, MEM_WORD_U, MEM_ILLEGAL
    } mem_ctrl_e;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, state_nxt;
    logic               last_grant;
    logic               gnt_idx;
    logic               grant;
    logic               grant_sel;
    logic               lat_we;
    logic [WIDTH-1:0]   lat_addr;
    logic [WIDTH-1:0]   lat_wdata;
    logic [2:0]         lat_ctrl;
    logic               illegal;

    // Stores only exist in the four signed sizes; code 7 is invalid for anything.
    assign illegal = (lat_ctrl == MEM_ILLEGAL) || (lat_we && (lat_ctrl > MEM_DWORD));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        grant_sel    = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_ctrl     = '0;
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        case (state)
            IDLE: begin
                // Gate with rst_n so readys stay low while reset is held.
                grant     = rst_n && (req0_valid || req1_valid);
                grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                if (grant) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt    = RESP;
                mem_addr     = lat_addr;
                mem_wdata    = lat_wdata;
                mem_ctrl     = lat_ctrl;
                mem_MemRead  = ~illegal & ~lat_we;
                mem_MemWrite = ~illegal & lat_we;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        req0_ready = grant & ~grant_sel;
        req1_ready = grant & grant_sel;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            gnt_idx     <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_ctrl    <= '0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_err    <= 1'b0;
            req1_err    <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            if (grant) begin
                gnt_idx    <= grant_sel;
                last_grant <= grant_sel;
                lat_we     <= grant_sel ? req1_we    : req0_we;
                lat_addr   <= grant_sel ? req1_addr  : req0_addr;
                lat_wdata  <= grant_sel ? req1_wdata : req0_wdata;
                lat_ctrl   <= grant_sel ? req1_ctrl  : req0_ctrl;
            end
            // Completion flags are set for exactly the RESP cycle that follows ACCESS.
            req0_rvalid <= (state == ACCESS) && !gnt_idx;
            req1_rvalid <= (state == ACCESS) && gnt_idx;
            req0_err    <= (state == ACCESS) && !gnt_idx && illegal;
            req1_err    <= (state == ACCESS) && gnt_idx && illegal;
            if ((state == ACCESS) && !illegal && !lat_we) begin
                if (gnt_idx) begin
                    req1_rdata <= mem_rdata;
                end else begin
                    req0_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-timing model checked every cycle, plus directed
// scenarios with hand-computed results.
module tb_dmem_arbiter;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready, req0_we, req0_rvalid, req0_err;
    logic [W-1:0]  req0_addr, req0_wdata, req0_rdata;
    logic [2:0]    req0_ctrl;
    logic          req1_valid, req1_ready, req1_we, req1_rvalid, req1_err;
    logic [W-1:0]  req1_addr, req1_wdata, req1_rdata;
    logic [2:0]    req1_ctrl;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
    logic [2:0]    mem_ctrl;
    logic          mem_MemRead, mem_MemWrite;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ctrl(req0_ctrl),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ctrl(req1_ctrl),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_rdata(mem_rdata)
    );

    // Load/store semantics of the memControl codes (RISC-V funct3 style).
    function automatic logic [63:0] ld(input logic [63:0] w, input logic [2:0] off,
                                       input logic [2:0] c);
        logic [63:0] s;
        s = w >> {off, 3'b000};
        case (c)
            3'd0:    return {{56{s[7]}}, s[7:0]};
            3'd1:    return {{48{s[15]}}, s[15:0]};
            3'd2:    return {{32{s[31]}}, s[31:0]};
            3'd3:    return w;
            3'd4:    return {56'b0, s[7:0]};
            3'd5:    return {48'b0, s[15:0]};
            3'd6:    return {32'b0, s[31:0]};
            default: return 64'b0;
        endcase
    endfunction

    function automatic logic [63:0] st(input logic [63:0] w, input logic [2:0] off,
                                       input logic [2:0] c, input logic [63:0] d);
        logic [63:0] m;
        case (c)
            3'd0:    m = 64'hFF;
            3'd1:    m = 64'hFFFF;
            3'd2:    m = 64'hFFFF_FFFF;
            3'd3:    m = '1;
            default: return w;
        endcase
        return (w & ~(m << {off, 3'b000})) | ((d & m) << {off, 3'b000});
    endfunction

    // Data memory the arbiter drives: combinational read, posedge write.
    logic [63:0] mem     [0:31];
    logic [63:0] ref_mem [0:31];
    assign mem_rdata = ld(mem[mem_addr[7:3]], mem_addr[2:0], mem_ctrl);
    always @(posedge clk) begin
        if (mem_MemWrite) mem[mem_addr[7:3]] <= st(mem[mem_addr[7:3]], mem_addr[2:0], mem_ctrl, mem_wdata);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: an accepted request occupies the memory for the next cycle and
    // completes the cycle after; nothing new is accepted until three cycles after acceptance.
    typedef struct { int c; bit p; } acc_t;
    acc_t        acc_log[$];
    int          cyc = 0, next_free = 0, t_cyc = 0;
    bit          infl = 0, last = 1, t_port = 0, t_we = 0;
    bit          m_any, m_g, in_acc, in_resp, ill;
    logic [63:0] t_addr = 0, t_wd = 0, m_rdata0 = 0, m_rdata1 = 0;
    logic [2:0]  t_ctrl = 0;

    initial begin : model
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                infl = 0; last = 1; next_free = cyc; m_rdata0 = 0; m_rdata1 = 0;
            end else begin
                m_any   = (cyc >= next_free) && (req0_valid || req1_valid);
                m_g     = (req0_valid && req1_valid) ? ~last : req1_valid;
                in_acc  = infl && (cyc == t_cyc + 1);
                in_resp = infl && (cyc == t_cyc + 2);
                ill     = (t_ctrl == 3'd7) || (t_we && t_ctrl > 3'd3);
                check("ready0", req0_ready, m_any && !m_g);
                check("ready1", req1_ready, m_any && m_g);
                check("one_ready", req0_ready & req1_ready, 0);
                check("mem_MemRead", mem_MemRead, in_acc && !ill && !t_we);
                check("mem_MemWrite", mem_MemWrite, in_acc && !ill && t_we);
                check("mem_addr", mem_addr, in_acc ? t_addr : 64'b0);
                check("mem_wdata", mem_wdata, in_acc ? t_wd : 64'b0);
                check("mem_ctrl", mem_ctrl, in_acc ? t_ctrl : 3'b0);
                check("rvalid0", req0_rvalid, in_resp && !t_port);
                check("rvalid1", req1_rvalid, in_resp && t_port);
                check("err0", req0_err, in_resp && !t_port && ill);
                check("err1", req1_err, in_resp && t_port && ill);
                check("rdata0", req0_rdata, m_rdata0);
                check("rdata1", req1_rdata, m_rdata1);
                if (req0_ready || req1_ready) acc_log.push_back('{cyc, req1_ready});
                if (in_acc && !ill) begin
                    if (t_we) ref_mem[t_addr[7:3]] = st(ref_mem[t_addr[7:3]], t_addr[2:0], t_ctrl, t_wd);
                    else if (t_port) m_rdata1 = ld(ref_mem[t_addr[7:3]], t_addr[2:0], t_ctrl);
                    else m_rdata0 = ld(ref_mem[t_addr[7:3]], t_addr[2:0], t_ctrl);
                end
                if (in_resp) infl = 0;
                if (m_any) begin
                    infl   = 1;
                    t_port = m_g;
                    t_we   = m_g ? req1_we : req0_we;
                    t_addr = m_g ? req1_addr : req0_addr;
                    t_wd   = m_g ? req1_wdata : req0_wdata;
                    t_ctrl = m_g ? req1_ctrl : req0_ctrl;
                    t_cyc  = cyc;
                    last   = m_g;
                    next_free = cyc + 3;
                end
                cyc++;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_rdata0"}, req0_rdata, 0);
        check({tag, "_rdata1"}, req1_rdata, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_flags"}, {req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_err,
                                req1_err, mem_MemRead, mem_MemWrite, mem_ctrl}, 0);
    endtask

    // One request on port p; reports what the memory port and the response looked like.
    task automatic do_req(input bit p, input bit we, input logic [63:0] a, input logic [63:0] wd,
                          input logic [2:0] c, output logic acc_rd, output logic acc_wr,
                          output logic [63:0] acc_addr, output logic rv, output logic er);
        bit got;
        acc_rd = 0; acc_wr = 0; acc_addr = 0; rv = 0; er = 0;
        if (p) begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = wd; req1_ctrl = c; end
        else   begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = wd; req0_ctrl = c; end
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin got = 1; break; end
        end
        check("accept", got, 1);
        @(posedge clk); #1;
        // Scramble the inputs after acceptance; the in-flight access must not notice.
        if (p) begin req1_valid = 0; req1_we = ~we; req1_addr = ~a; req1_wdata = ~wd; req1_ctrl = 3'd5; end
        else   begin req0_valid = 0; req0_we = ~we; req0_addr = ~a; req0_wdata = ~wd; req0_ctrl = 3'd5; end
        if (got) begin
            @(negedge clk);
            acc_rd = mem_MemRead; acc_wr = mem_MemWrite; acc_addr = mem_addr;
            @(posedge clk); #1;
            @(negedge clk);
            rv = p ? req1_rvalid : req0_rvalid;
            er = p ? req1_err : req0_err;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 0; req0_valid = 0; req1_valid = 0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    logic        a_rd, a_wr, rv, er;
    logic [63:0] a_addr;
    int          cnt, c0;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        mem[2] = 64'h1122_3344_5566_7788;
        for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0; req0_ctrl = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0; req1_ctrl = 0;
        #2 check_zero("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Single dword load from port 0.
        do_req(0, 0, 64'h10, 64'h0, 3'd3, a_rd, a_wr, a_addr, rv, er);
        check("ld_memread", a_rd, 1);
        check("ld_memwrite", a_wr, 0);
        check("ld_addr", a_addr, 64'h10);
        check("ld_rvalid", rv, 1);
        check("ld_rdata", req0_rdata, 64'h1122_3344_5566_7788);

        // Store then load on port 1.
        do_req(1, 1, 64'h8, 64'hDEADBEEF, 3'd3, a_rd, a_wr, a_addr, rv, er);
        check("st_memwrite", a_wr, 1);
        check("st_rvalid", rv, 1);
        check("st_err", er, 0);
        check("st_mem", mem[1], 64'h0000_0000_DEAD_BEEF);
        do_req(1, 0, 64'h8, 64'h0, 3'd3, a_rd, a_wr, a_addr, rv, er);
        check("st_ld_rdata", req1_rdata, 64'h0000_0000_DEAD_BEEF);

        // Illegal store (MEM_WORD_U): no write, error flagged, rdata untouched.
        do_req(0, 1, 64'h18, 64'hCAFE, 3'd6, a_rd, a_wr, a_addr, rv, er);
        check("ill_memwrite", a_wr, 0);
        check("ill_memread", a_rd, 0);
        check("ill_rvalid", rv, 1);
        check("ill_err", er, 1);
        check("ill_mem", mem[3], 64'hA5A5_0000_0000_0003);
        check("ill_rdata", req0_rdata, 64'h1122_3344_5566_7788);

        // Sub-word loads: signed byte and unsigned halfword.
        do_req(1, 0, 64'h10, 64'h0, 3'd0, a_rd, a_wr, a_addr, rv, er);
        check("lb_rdata", req1_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        do_req(0, 0, 64'h12, 64'h0, 3'd5, a_rd, a_wr, a_addr, rv, er);
        check("lhu_rdata", req0_rdata, 64'h0000_0000_0000_5566);

        // Load with ctrl 7 is illegal too.
        do_req(1, 0, 64'h10, 64'h0, 3'd7, a_rd, a_wr, a_addr, rv, er);
        check("ill7_memread", a_rd, 0);
        check("ill7_err", er, 1);
        check("ill7_rdata", req1_rdata, 64'hFFFF_FFFF_FFFF_FF88);

        // Reset while a load is in ACCESS.
        req0_valid = 1; req0_we = 0; req0_addr = 64'h10; req0_ctrl = 3'd3;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req0_ready) begin cnt = 1; break; end
        end
        check("mid_accept", cnt, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        check("mid_in_access", mem_MemRead, 1);
        rst_n = 0;
        #1 check_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (req0_rvalid || req1_rvalid) cnt++;
        end
        check("mid_no_rvalid", cnt, 0);
        @(posedge clk); #1;
        do_req(0, 0, 64'h8, 64'h0, 3'd3, a_rd, a_wr, a_addr, rv, er);
        check("mid_after_rvalid", rv, 1);
        check("mid_after_rdata", req0_rdata, 64'h0000_0000_DEAD_BEEF);

        // Contention: both ports valid continuously from reset release.
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        acc_log.delete();
        c0 = cyc;
        rst_n = 1;
        req0_valid = 1; req0_we = 0; req0_addr = 64'h10; req0_ctrl = 3'd3;
        req1_valid = 1; req1_we = 0; req1_addr = 64'h08; req1_ctrl = 3'd3;
        repeat (11) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        check("cont_count", acc_log.size(), 4);
        if (acc_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("cont_port%0d", i), acc_log[i].p, i % 2);
                check($sformatf("cont_cycle%0d", i), acc_log[i].c - c0, 3 * i);
            end
        end
        check("cont_rdata0", req0_rdata, 64'h1122_3344_5566_7788);
        check("cont_rdata1", req1_rdata, 64'h0000_0000_DEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data/address width of both requesters and the memory port.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have, per requester N in {0,1}: reqN_valid (input, 1), request present; reqN_ready (output, 1), request accepted this cycle.
REQ-005 SHALL have, per requester N: reqN_we (input, 1), 1 = store, 0 = load; reqN_addr (input, WIDTH), byte address; reqN_wdata (input, WIDTH), store data; reqN_ctrl (input, 3), memControl size/sign code.
REQ-006 SHALL have, per requester N: reqN_rvalid (output, 1), completion pulse; reqN_rdata (output, WIDTH), load data; reqN_err (output, 1), illegal request flag, valid with rvalid.
REQ-007 SHALL have memory-side ports: mem_addr (output, WIDTH), mem_wdata (output, WIDTH), mem_ctrl (output, 3), mem_MemRead (output, 1), mem_MemWrite (output, 1), mem_rdata (input, WIDTH), wired to one data-memory instance with combinational read and posedge write.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on grant, ACCESS->RESP always, RESP->IDLE always.
REQ-009 In IDLE with exactly one reqN_valid high, SHALL assert that reqN_ready combinationally in the same cycle and latch we/addr/wdata/ctrl plus the grant index at the clock edge.
REQ-010 In IDLE with both valid, SHALL grant the port not granted last (round-robin); last_grant updates on each grant.
REQ-011 SHALL never assert reqN_ready outside IDLE, nor more than one reqN_ready in any cycle.
REQ-012 In ACCESS, SHALL drive mem_addr/mem_wdata/mem_ctrl from latched values, mem_MemRead = ~we, mem_MemWrite = we; the store commits at the ACCESS->RESP edge.
REQ-013 Outside ACCESS, SHALL hold mem_MemRead = mem_MemWrite = 0, mem_addr = mem_wdata = 0, mem_ctrl = 0.
REQ-014 At the ACCESS->RESP edge, SHALL register mem_rdata into the granted port's reqN_rdata for loads; stores leave reqN_rdata unchanged.
REQ-015 In RESP, SHALL assert reqN_rvalid of the granted port only, for exactly one cycle; reqN_rdata holds its value until that port's next load completes.
REQ-016 Latency: accept in cycle T, ACCESS in T+1, rvalid in T+2; next accept no earlier than T+3.
REQ-017 A store with ctrl not in {MEM_BYTE, MEM_HALFWORD, MEM_WORD, MEM_DWORD}, or any request with ctrl = 3'b111, SHALL be illegal: ACCESS keeps mem_MemWrite and mem_MemRead 0, RESP asserts reqN_err with reqN_rvalid, and reqN_rdata is unchanged.
REQ-018 reqN_err SHALL be 0 whenever reqN_rvalid is 0.
REQ-019 Request inputs that change after acceptance SHALL NOT affect the in-flight access.

Reset
REQ-020 On rst_n low, SHALL asynchronously force state IDLE, last_grant = 1 (port 0 wins the first tie), all reqN_ready/rvalid/err = 0, all reqN_rdata = 0, all mem_* outputs = 0.
REQ-021 Reset during ACCESS SHALL abort the access: no completion pulse; a store's commit is not guaranteed.
REQ-022 After rst_n deasserts, the first grant SHALL be possible in the first IDLE cycle.

Verification
REQ-023 Single load: req0 valid, we=0, addr=0x10, ctrl=MEM_DWORD; memory word 2 = 0x1122334455667788 -> ready0 in T, mem_MemRead=1 and mem_addr=0x10 in T+1, rvalid0=1 and rdata0=0x1122334455667788 in T+2.
REQ-024 Store then load: req1 store addr=0x8, wdata=0xDEADBEEF, ctrl=MEM_DWORD, then load of the same address -> rvalid1 pulses for the store, and the load returns 0x00000000DEADBEEF.
REQ-025 Contention: both valid continuously after reset -> grants alternate 0,1,0,1 with accepts at T, T+3, T+6, T+9, and never two readys in one cycle.
REQ-026 Illegal store: req0 store with ctrl=MEM_WORD_U -> mem_MemWrite stays 0 in ACCESS, rvalid0=1 and err0=1 in RESP, and memory is unchanged.
REQ-027 Reset mid-op: rst_n low during ACCESS of a load -> all outputs 0 immediately, no rvalid after release, and a new request is accepted normally.
